// File: rtl/fdiv_pkg.sv
// Shared definitions for the sequential fractional divider: default width,
// FSM state encoding and the iteration-counter width helper.
package fdiv_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(N_DEF);

endpackage

// File: rtl/fdiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module fdiv_step #(
    parameter int N = 8
) (
    input  logic [N:0] i_p,
    input  logic       i_bit,
    input  logic [N:0] i_dv,
    output logic [N:0] o_p,
    output logic       o_q
);

    logic [N+1:0] t;
    logic [N+1:0] dv_ext;

    assign t      = {i_p, i_bit};
    assign dv_ext = {1'b0, i_dv};
    assign o_q    = (t >= dv_ext);
    // The partial remainder stays below the divisor, so N+1 bits always hold it.
    assign o_p    = (N+1)'(o_q ? (t - dv_ext) : t);

endmodule

// File: rtl/fdiv_seq.sv
// Sequential 1.15 / 1.7 unsigned fractional divider producing a 1.7 quotient
// and remainder, one quotient bit per clock.
module fdiv_seq
    import fdiv_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_r1,
    input  logic [N-1:0] i_r0,
    input  logic [N-1:0] i_rr,
    output logic         o_busy,
    output logic         o_valid,
    output logic [N-1:0] o_q,
    output logic [N:0]   o_rem,
    output logic         o_dz,
    output logic         o_ov
);

    localparam int CW = cnt_w(N);

    state_e        state_q;
    logic [N:0]    p_q;
    logic [N:0]    dv_q;
    logic [N-1:0]  lo_q;
    logic [N-1:0]  qs_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    p_d;
    logic          q_bit_d;
    logic [N:0]    dv_in;
    logic          dz_in;
    logic          ov_in;

    // The divisor is 1.7 against a 1.15 dividend, hence the extra zero LSB.
    assign dv_in = {i_rr, 1'b0};
    assign dz_in = (i_rr == '0);
    assign ov_in = !dz_in && ({1'b0, i_r1} >= dv_in);

    fdiv_step #(.N(N)) u_step (
        .i_p   (p_q),
        .i_bit (lo_q[N-1]),
        .i_dv  (dv_q),
        .o_p   (p_d),
        .o_q   (q_bit_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            dv_q    <= '0;
            lo_q    <= '0;
            qs_q    <= '0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_q     <= '0;
            o_rem   <= '0;
            o_dz    <= 1'b0;
            o_ov    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_valid <= 1'b0;
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (dz_in || ov_in) begin
                            state_q <= DONE;
                            o_valid <= 1'b1;
                            o_q     <= '1;
                            o_rem   <= '0;
                            o_dz    <= dz_in;
                            o_ov    <= ov_in;
                        end else begin
                            state_q <= CALC;
                            o_dz    <= 1'b0;
                            o_ov    <= 1'b0;
                            p_q     <= {1'b0, i_r1};
                            lo_q    <= i_r0;
                            dv_q    <= dv_in;
                            cnt_q   <= CW'(N - 1);
                        end
                    end
                end
                CALC: begin
                    p_q  <= p_d;
                    lo_q <= {lo_q[N-2:0], 1'b0};
                    qs_q <= {qs_q[N-2:0], q_bit_d};
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        o_valid <= 1'b1;
                        o_q     <= {qs_q[N-2:0], q_bit_d};
                        o_rem   <= p_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: a divide model from plain integer arithmetic,
// a per-cycle compare process, and literal expectations from worked examples.
module tb_fdiv_seq;

    typedef struct {
        logic [7:0] q;
        logic [8:0] rem;
        logic       dz;
        logic       ov;
        int         due;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_r1 = '0;
    logic [7:0] i_r0 = '0;
    logic [7:0] i_rr = '0;
    logic       o_busy;
    logic       o_valid;
    logic [7:0] o_q;
    logic [8:0] o_rem;
    logic       o_dz;
    logic       o_ov;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_until = -10;
    int   valid_cnt = 0;
    res_t exp_q[$];
    res_t last = '{q: 8'h00, rem: 9'h000, dz: 1'b0, ov: 1'b0, due: 0};

    fdiv_seq #(.N(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .i_r1    (i_r1),
        .i_r0    (i_r0),
        .i_rr    (i_rr),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_q     (o_q),
        .o_rem   (o_rem),
        .o_dz    (o_dz),
        .o_ov    (o_ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Divide from the arithmetic definition: Q = D / (2*rr), R = D mod (2*rr).
    function automatic res_t model(input logic [7:0] r1, input logic [7:0] r0, input logic [7:0] rr);
        res_t        r;
        int unsigned d;
        int unsigned dv;
        d  = {16'h0, r1, r0};
        dv = 2 * int'(rr);
        r  = '{q: 8'hFF, rem: 9'h000, dz: 1'b0, ov: 1'b0, due: 0};
        if (rr == 8'h00)
            r.dz = 1'b1;
        else if (d / dv >= 256)
            r.ov = 1'b1;
        else begin
            r.q   = 8'(d / dv);
            r.rem = 9'(d % dv);
        end
        return r;
    endfunction

    // Model of acceptance: a start is taken only when the divider is idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            busy_until = -10;
            last = '{q: 8'h00, rem: 9'h000, dz: 1'b0, ov: 1'b0, due: 0};
        end else begin
            cyc++;
            if (i_start && cyc >= busy_until + 2) begin
                res_t r;
                r = model(i_r1, i_r0, i_rr);
                r.due = cyc + ((r.dz || r.ov) ? 0 : 8);
                busy_until = r.due;
                exp_q.push_back(r);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", o_busy, (cyc <= busy_until));
            if (o_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", o_valid, 1'b0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("valid_cycle", cyc, r.due);
                    chk("q", o_q, r.q);
                    chk("rem", o_rem, r.rem);
                    chk("dz", o_dz, r.dz);
                    chk("ov", o_ov, r.ov);
                    last = r;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                chk("valid_missing", o_valid, 1'b1);
                void'(exp_q.pop_front());
            end
            if (cyc > busy_until) begin
                chk("hold_q", o_q, last.q);
                chk("hold_rem", o_rem, last.rem);
                chk("hold_dz", o_dz, last.dz);
                chk("hold_ov", o_ov, last.ov);
                chk("idle_valid", o_valid, 1'b0);
            end
        end
    end

    // One operation; optionally pulses a junk start on cycle ign of the run.
    task automatic do_op(input string nm, input logic [7:0] r1, input logic [7:0] r0,
                         input logic [7:0] rr, input logic [7:0] eq, input logic [8:0] er,
                         input logic edz, input logic eov, input int ebusy, input int ign);
        int busy_n = 0;
        bit got = 0;
        @(negedge clk);
        i_r1 = r1; i_r0 = r0; i_rr = rr; i_start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            i_start = (k + 1 == ign);
            if (k + 1 == ign) begin
                i_r1 = 8'h55; i_r0 = 8'hAA; i_rr = 8'h01;
            end
            if (o_busy) busy_n++;
            if (o_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        chk({nm, "_got_valid"}, got, 1'b1);
        chk({nm, "_busy_cycles"}, busy_n, ebusy);
        if (got) begin
            chk({nm, "_q"}, o_q, eq);
            chk({nm, "_rem"}, o_rem, er);
            chk({nm, "_dz"}, o_dz, edz);
            chk({nm, "_ov"}, o_ov, eov);
        end
    endtask

    initial begin
        int vc0;
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_q", o_q, 8'h00);
        chk("rst_rem", o_rem, 9'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op("exact",   8'hF0, 8'h00, 8'hA0, 8'hC0, 9'h000, 1'b0, 1'b0, 9, 0);
        do_op("inexact", 8'h12, 8'h34, 8'h40, 8'h24, 9'h034, 1'b0, 1'b0, 9, 0);
        do_op("extreme", 8'hFF, 8'hFE, 8'hFF, 8'h80, 9'h0FE, 1'b0, 1'b0, 9, 0);
        do_op("zero",    8'h00, 8'h00, 8'h55, 8'h00, 9'h000, 1'b0, 1'b0, 9, 0);
        do_op("maxhi",   8'h7F, 8'hFF, 8'h40, 8'hFF, 9'h07F, 1'b0, 1'b0, 9, 0);
        do_op("dz",      8'h12, 8'h34, 8'h00, 8'hFF, 9'h000, 1'b1, 1'b0, 1, 0);
        do_op("ov",      8'hFF, 8'hFF, 8'h01, 8'hFF, 9'h000, 1'b0, 1'b1, 1, 0);
        do_op("ov_rr1",  8'h02, 8'h00, 8'h01, 8'hFF, 9'h000, 1'b0, 1'b1, 1, 0);
        do_op("clear",   8'h12, 8'h34, 8'h40, 8'h24, 9'h034, 1'b0, 1'b0, 9, 0);
        do_op("ignore",  8'h12, 8'h34, 8'h40, 8'h24, 9'h034, 1'b0, 1'b0, 9, 3);

        // Start held high: one operation every ten cycles.
        @(negedge clk);
        vc0 = valid_cnt;
        i_r1 = 8'h12; i_r0 = 8'h34; i_rr = 8'h40; i_start = 1'b1;
        repeat (30) @(negedge clk);
        i_start = 1'b0;
        repeat (15) @(negedge clk);
        chk("held_start_valids", valid_cnt - vc0, 3);

        // Reset during the fourth CALC cycle.
        @(negedge clk);
        i_r1 = 8'hF0; i_r0 = 8'h00; i_rr = 8'hA0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_q", o_q, 8'h00);
        chk("mid_rst_rem", o_rem, 9'h000);
        chk("mid_rst_dz", o_dz, 1'b0);
        chk("mid_rst_ov", o_ov, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op("after_rst", 8'hF0, 8'h00, 8'hA0, 8'hC0, 9'h000, 1'b0, 1'b0, 9, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
